// File: rtl/stream_out_serializer_if.sv
// Handshake/data bundle for stream_out_serializer: parallel source in, serial stream out.
interface stream_out_serializer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TOTAL_ELEM = 10
);
  logic [TOTAL_ELEM-1:0][DATA_WIDTH-1:0] bus_data_i;
  logic                                  start_stream_i;
  logic                                  stream_clr_i;
  logic [DATA_WIDTH-1:0]                 stream_data_o;
  logic                                  stream_valid_o;

  modport master (
    output bus_data_i,
    output start_stream_i,
    output stream_clr_i,
    input  stream_data_o,
    input  stream_valid_o
  );

  modport slave (
    input  bus_data_i,
    input  start_stream_i,
    input  stream_clr_i,
    output stream_data_o,
    output stream_valid_o
  );
endinterface

// File: rtl/stream_out_serializer.sv
// Parallel-to-serial output stage: snapshots TOTAL_ELEM words on a start pulse and
// emits them one per clock, element 0 first, qualified by stream_valid_o.
module stream_out_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RESET_VAL  = 0,
  parameter int unsigned TOTAL_ELEM = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  stream_out_serializer_if.slave  bus
);

  localparam int unsigned IDX_WIDTH = $clog2(TOTAL_ELEM);
  // idx must reach TOTAL_ELEM itself, which needs one extra bit for powers of two
  localparam int unsigned CNT_W = ((1 << IDX_WIDTH) == TOTAL_ELEM) ? IDX_WIDTH + 1 : IDX_WIDTH;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  localparam logic [DATA_WIDTH-1:0] RST_DATA = DATA_WIDTH'(RESET_VAL);
  localparam logic [CNT_W-1:0]      IDX_END  = CNT_W'(TOTAL_ELEM);

  logic [0:0]                            state;
  logic [CNT_W-1:0]                      idx;
  logic [TOTAL_ELEM-1:0][DATA_WIDTH-1:0] snap;
  logic [DATA_WIDTH-1:0]                 data_q;
  logic                                  valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      idx     <= '0;
      snap    <= '0;
      data_q  <= RST_DATA;
      valid_q <= 1'b0;
    end else if (bus.stream_clr_i) begin
      state   <= IDLE;
      idx     <= '0;
      data_q  <= RST_DATA;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_stream_i) begin
            // element 0 goes straight out; the rest are served from the snapshot
            snap    <= bus.bus_data_i;
            data_q  <= bus.bus_data_i[0];
            valid_q <= 1'b1;
            idx     <= CNT_W'(1);
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (idx < IDX_END) begin
            data_q <= snap[idx];
            idx    <= idx + CNT_W'(1);
          end else begin
            data_q  <= RST_DATA;
            valid_q <= 1'b0;
            idx     <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          idx     <= '0;
          data_q  <= RST_DATA;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stream_data_o  = data_q;
  assign bus.stream_valid_o = valid_q;

endmodule

// File: tb/tb_stream_out_serializer.sv
// Directed self-checking bench for stream_out_serializer (DATA_WIDTH=16, TOTAL_ELEM=10).
module tb_stream_out_serializer;

  localparam int unsigned DW = 16;
  localparam int unsigned NE = 10;

  logic clk_i = 1'b0;
  logic rst_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] exp_q [NE];

  stream_out_serializer_if #(.DATA_WIDTH(DW), .TOTAL_ELEM(NE)) sif ();

  stream_out_serializer #(
    .DATA_WIDTH(DW),
    .RESET_VAL (0),
    .TOTAL_ELEM(NE)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (sif.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, {31'd0, sif.stream_valid_o}, 32'd0);
    check_eq({tag, "_data"}, {16'd0, sif.stream_data_o}, 32'd0);
  endtask

  // Load exp_q onto the bus, pulse start, overwrite the bus, and check every element.
  // restart_at > 0 raises start again just before edge E0+restart_at.
  task automatic run_stream(input string tag, input int restart_at);
    for (int i = 0; i < NE; i++) sif.bus_data_i[i] = exp_q[i];
    sif.start_stream_i = 1'b1;
    tick();
    sif.start_stream_i = 1'b0;
    sif.bus_data_i = '1;
    for (int i = 0; i < NE; i++) begin
      if (i > 0) begin
        if (i == restart_at) sif.start_stream_i = 1'b1;
        tick();
        sif.start_stream_i = 1'b0;
      end
      check_eq($sformatf("%s_e%0d_data", tag, i), {16'd0, sif.stream_data_o}, {16'd0, exp_q[i]});
      check_eq($sformatf("%s_e%0d_valid", tag, i), {31'd0, sif.stream_valid_o}, 32'd1);
    end
    tick();
    check_idle({tag, "_end"});
  endtask

  initial begin
    rst_i = 1'b1;
    sif.bus_data_i     = '0;
    sif.start_stream_i = 1'b0;
    sif.stream_clr_i   = 1'b0;

    // reset held for 3 cycles
    repeat (3) tick();
    check_idle("reset");
    rst_i = 1'b0;
    repeat (2) tick();
    check_idle("post_reset");

    // basic stream with snapshot (bus overwritten with 0xFFFF after E0)
    for (int i = 0; i < NE; i++) exp_q[i] = 16'hA500 + 16'(i * 16'h0103);
    run_stream("basic", 0);

    // start during STREAM at E0+3 is ignored
    for (int i = 0; i < NE; i++) exp_q[i] = 16'h1234 ^ 16'(i * 16'h1111);
    run_stream("restart_ign", 3);

    // clear mid-stream at E0+4
    for (int i = 0; i < NE; i++) exp_q[i] = 16'h0F00 + 16'(i);
    for (int i = 0; i < NE; i++) sif.bus_data_i[i] = exp_q[i];
    sif.start_stream_i = 1'b1;
    tick();
    sif.start_stream_i = 1'b0;
    repeat (3) tick();
    check_eq("clr_pre_data", {16'd0, sif.stream_data_o}, {16'd0, exp_q[3]});
    sif.stream_clr_i = 1'b1;
    tick();
    sif.stream_clr_i = 1'b0;
    check_idle("clr");
    tick();
    check_idle("clr_hold");
    run_stream("after_clr", 0);

    // start held across E10 (ignored) is accepted at E10+1
    for (int i = 0; i < NE; i++) exp_q[i] = 16'h8000 | 16'(i << 4);
    for (int i = 0; i < NE; i++) sif.bus_data_i[i] = exp_q[i];
    sif.start_stream_i = 1'b1;
    tick();
    sif.start_stream_i = 1'b0;
    repeat (NE - 1) tick();
    check_eq("edge_last_data", {16'd0, sif.stream_data_o}, {16'd0, exp_q[NE-1]});
    sif.start_stream_i = 1'b1;
    tick();
    check_idle("edge_e10");
    tick();
    sif.start_stream_i = 1'b0;
    check_eq("edge_e11_valid", {31'd0, sif.stream_valid_o}, 32'd1);
    check_eq("edge_e11_data", {16'd0, sif.stream_data_o}, {16'd0, exp_q[0]});
    sif.stream_clr_i = 1'b1;
    tick();
    sif.stream_clr_i = 1'b0;
    check_idle("edge_clr");

    // clear and start on the same edge stays idle
    sif.stream_clr_i   = 1'b1;
    sif.start_stream_i = 1'b1;
    tick();
    sif.stream_clr_i   = 1'b0;
    sif.start_stream_i = 1'b0;
    check_idle("clr_start");
    tick();
    check_idle("clr_start_hold");

    // asynchronous reset 2ns after E0+5
    for (int i = 0; i < NE; i++) exp_q[i] = 16'h5A5A - 16'(i * 7);
    for (int i = 0; i < NE; i++) sif.bus_data_i[i] = exp_q[i];
    sif.start_stream_i = 1'b1;
    tick();
    sif.start_stream_i = 1'b0;
    repeat (4) tick();
    check_eq("arst_pre_data", {16'd0, sif.stream_data_o}, {16'd0, exp_q[4]});
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_idle("arst");
    tick();
    rst_i = 1'b0;
    tick();
    check_idle("arst_release");
    run_stream("after_arst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
